// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg -- shared constants, the pipeline stage record and the
// carry-lookahead helper functions used by sub64_pipe and cla16.
// ---------------------------------------------------------------------------
package arith_pkg;

    localparam int DATA_W  = 64;
    localparam int SLICE_W = 16;
    localparam int STAGES  = DATA_W / SLICE_W;
    localparam int GROUP_W = 4;

    // One pipeline stage. diff holds the bits resolved so far; opa/opb still
    // carry the unresolved upper operand bits (and the sign bits for ovf).
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] diff;
        logic [DATA_W-1:0] opa;
        logic [DATA_W-1:0] opb;
        logic              carry;   // carry into the next slice
        logic              zero;    // all resolved diff bits are zero
    } stage_t;

    // Carries c[0..4] of a 4-wide lookahead group: c[0] = ci, c[4] = group carry-out.
    // Every carry is a flat sum of products; nothing ripples.
    function automatic logic [GROUP_W:0] lookahead4(input logic [GROUP_W-1:0] g,
                                                    input logic [GROUP_W-1:0] p,
                                                    input logic ci);
        logic [GROUP_W:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | ((&p) & ci);
        return c;
    endfunction

    // Group generate of a 4-wide group (carry-out assuming ci = 0).
    function automatic logic group_gen(input logic [GROUP_W-1:0] g,
                                       input logic [GROUP_W-1:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

endpackage

// File: rtl/cla16.sv
// ---------------------------------------------------------------------------
// cla16 -- 16-bit carry-lookahead adder slice: s = x + y + ci, co = carry-out.
// Built from four 4-bit groups; group generate/propagate feed a second
// lookahead level that produces the group carry-ins and the slice carry-out.
//   x, y : addends (16 bits)
//   ci   : carry-in
//   s    : sum (16 bits)
//   co   : carry-out of bit 15
// ---------------------------------------------------------------------------
module cla16
    import arith_pkg::*;
(
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    localparam int GROUPS = SLICE_W / GROUP_W;

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] c;
    logic [GROUPS-1:0]  gg;
    logic [GROUPS-1:0]  gp;
    logic [GROUPS:0]    gc;
    logic [GROUP_W:0]   bit_c;

    // NOTE: every variable gets a value before any branch or loop, so no latch can be inferred.
    always_comb begin
        g     = x & y;
        p     = x ^ y;
        c     = '0;
        gg    = '0;
        gp    = '0;
        bit_c = '0;

        for (int j = 0; j < GROUPS; j++) begin
            gg[j] = group_gen(g[GROUP_W*j +: GROUP_W], p[GROUP_W*j +: GROUP_W]);
            gp[j] = &p[GROUP_W*j +: GROUP_W];
        end

        gc = lookahead4(gg, gp, ci);

        for (int j = 0; j < GROUPS; j++) begin
            bit_c = lookahead4(g[GROUP_W*j +: GROUP_W], p[GROUP_W*j +: GROUP_W], gc[j]);
            c[GROUP_W*j +: GROUP_W] = bit_c[GROUP_W-1:0];
        end

        s  = p ^ c;
        co = gc[GROUPS];
    end

endmodule

// File: rtl/sub64_pipe.sv
// ---------------------------------------------------------------------------
// sub64_pipe -- 4-stage pipelined 64-bit subtractor, diff = a - b - bin.
// Implemented as a + ~b + ~bin; stage k resolves bits [16k+15:16k] with one
// cla16 slice. Valid/ready handshake on both sides; a stalled output freezes
// the whole pipeline.
//   clk, rst_n          : clock, asynchronous active-low reset
//   a, b, bin, in_valid : operand set and its valid, accepted when in_ready
//   in_ready            : ~stall, independent of in_valid
//   diff, bout, zero,
//   ovf, lt, out_valid  : result and flags, held while out_ready is low
//   out_ready           : consumer accepts the result
// ---------------------------------------------------------------------------
module sub64_pipe
    import arith_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              bin,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] diff,
    output logic              bout,
    output logic              zero,
    output logic              ovf,
    output logic              lt,
    output logic              out_valid,
    input  logic              out_ready
);

    stage_t st  [STAGES];   // stage registers; st[STAGES-1] drives the outputs
    stage_t src [STAGES];   // record entering each stage's slice
    stage_t nxt [STAGES];   // value each stage loads when the pipe shifts

    logic [STAGES-1:0][SLICE_W-1:0] slice_x;
    logic [STAGES-1:0][SLICE_W-1:0] slice_y;
    logic [STAGES-1:0][SLICE_W-1:0] slice_s;
    logic [STAGES-1:0]              slice_ci;
    logic [STAGES-1:0]              slice_co;

    logic stall;
    logic ovf_raw;
    logic unused_bits;

    assign stall    = st[STAGES-1].valid & ~out_ready;
    assign in_ready = ~stall;

    // Stage 0 sees a virtual record built from the inputs; carry-in is ~bin
    // and the subtrahend is inverted at every slice input.
    always_comb begin
        src[0] = '{valid: in_valid, diff: '0, opa: a, opb: b, carry: ~bin, zero: 1'b1};
        for (int k = 1; k < STAGES; k++) begin
            src[k] = st[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            slice_x[k]  = src[k].opa[SLICE_W*k +: SLICE_W];
            slice_y[k]  = ~src[k].opb[SLICE_W*k +: SLICE_W];
            slice_ci[k] = src[k].carry;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        cla16 u_cla (
            .x  (slice_x[k]),
            .y  (slice_y[k]),
            .ci (slice_ci[k]),
            .s  (slice_s[k]),
            .co (slice_co[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt[k]                               = src[k];
            nxt[k].diff[SLICE_W*k +: SLICE_W]    = slice_s[k];
            nxt[k].carry                         = slice_co[k];
            nxt[k].zero                          = src[k].zero & (slice_s[k] == '0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge values.
    // NOTE: the stage registers are flops, not a memory, so all of them are cleared by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                st[k] <= '0;
            end
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                st[k] <= nxt[k];
            end
        end
    end

    // Signed overflow: operands of different sign and result sign differs from a.
    assign ovf_raw = (st[STAGES-1].opa[DATA_W-1] ^ st[STAGES-1].opb[DATA_W-1])
                   & (st[STAGES-1].opa[DATA_W-1] ^ st[STAGES-1].diff[DATA_W-1]);

    // Flags are qualified by valid so reset and bubbles present all-zero flags
    // (a cleared carry would otherwise read as a borrow).
    assign out_valid = st[STAGES-1].valid;
    assign diff      = st[STAGES-1].diff;
    assign bout      = st[STAGES-1].valid & ~st[STAGES-1].carry;
    assign zero      = st[STAGES-1].valid & st[STAGES-1].zero;
    assign ovf       = st[STAGES-1].valid & ovf_raw;
    assign lt        = st[STAGES-1].valid & (st[STAGES-1].diff[DATA_W-1] ^ ovf_raw);

    // The last stage only needs the operand sign bits; the rest are spent.
    assign unused_bits = ^{st[STAGES-1].opa[DATA_W-2:0], st[STAGES-1].opb[DATA_W-2:0]};

endmodule

// File: tb/tb_sub64_pipe.sv
// ---------------------------------------------------------------------------
// tb_sub64_pipe -- directed, table-driven bench for sub64_pipe.
// ---------------------------------------------------------------------------
module tb_sub64_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;
    logic        lt;
    logic        out_valid;
    logic        out_ready;

    int nvec  = 0;
    int nfail = 0;

    sub64_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero),
        .ovf       (ovf),
        .lt        (lt),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        bin;
        logic [63:0] d;
        logic        bo;
        logic        z;
        logic        o;
        logic        l;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [68:0] got, input logic [68:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // {out_valid, diff, bout, zero, ovf, lt}
    function automatic logic [68:0] outs();
        return {out_valid, diff, bout, zero, ovf, lt};
    endfunction

    initial begin
        int          cyc;
        int          sent;
        int          got;
        logic [63:0] expq [$];

        vecs[0] = '{64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{64'h0001_0000_0000_0000, 64'd0, 1'b1, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{64'h1234, 64'h1234, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{64'd1, 64'd0, 1'b1, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{64'h0000_0001_0000_0000, 64'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_n     = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        #1;
        check("reset_outputs", outs(), 69'd0);
        check("reset_in_ready", 69'(in_ready), 69'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset_in_ready", 69'(in_ready), 69'd1);

        // Single operations through an otherwise empty pipe.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a        = vecs[i].a;
            b        = vecs[i].b;
            bin      = vecs[i].bin;
            in_valid = 1'b1;
            @(negedge clk);             // accepted on this edge
            in_valid = 1'b0;
            repeat (2) @(negedge clk);  // three edges after acceptance
            if (i == 0) check("latency_not_early", 69'(out_valid), 69'd0);
            @(negedge clk);             // fourth edge: result present
            check($sformatf("vec%0d", i), outs(),
                  {1'b1, vecs[i].d, vecs[i].bo, vecs[i].z, vecs[i].o, vecs[i].l});
        end

        // Back-to-back stream with a 3-cycle output stall in the middle.
        @(negedge clk);
        cyc  = 0;
        sent = 0;
        got  = 0;
        while (got < 8 && cyc < 60) begin
            out_ready = !(cyc >= 6 && cyc <= 8);
            #1;
            if (out_valid && !out_ready) begin
                check("stall_in_ready", 69'(in_ready), 69'd0);
                check("stall_hold", {5'd0, diff}, {5'd0, expq[0]});
            end
            if (out_valid && out_ready) begin
                check($sformatf("stream%0d", got), {5'd0, diff}, {5'd0, expq.pop_front()});
                got++;
            end
            if (sent < 8) begin
                a        = 64'h0123_4567_89AB_CDEF + 64'(sent) * 64'h0001_0001_0001_1111;
                b        = 64'h0000_FFFF_0000_FFFF ^ 64'(sent);
                bin      = sent[0];
                in_valid = 1'b1;
                if (in_ready) begin
                    expq.push_back(a - b - 64'(bin));
                    sent++;
                end
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_delivered", 69'(got), 69'd8);

        // Reset with operations in flight: op0 at the output, three behind it.
        repeat (5) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            a        = 64'd100 + 64'(i);
            b        = 64'd1;
            bin      = 1'b0;
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("pre_reset_valid", 69'(out_valid), 69'd1);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", outs(), 69'd0);
        check("midreset_in_ready", 69'(in_ready), 69'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("no_stale%0d", i), 69'(out_valid), 69'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
